// File: rtl/mlp_param_loader.sv
// Loader for the MLP core's parameter banks: takes a framed word stream (header,
// W1, B1, W2, B2, XOR checksum) and turns it into one-cycle bank write strobes.
//
// state | meaning
// IDLE  | waiting for start, no load since reset
// HDR   | expecting the MAGIC header word
// W1    | receiving INPUT_NUM*NEURON_NUM layer-1 weights
// B1    | receiving NEURON_NUM layer-1 biases
// W2    | receiving NEURON_NUM*OUTPUT_NUM layer-2 weights
// B2    | receiving OUTPUT_NUM layer-2 biases
// CHK   | expecting the XOR checksum word
// DONE  | last load good, parameters valid
// ERR   | last load failed (bad header or checksum)
module mlp_param_loader #(
    parameter int INPUT_NUM  = 5,
    parameter int NEURON_NUM = 8,
    parameter int OUTPUT_NUM = 4,
    parameter int WORD_BIT   = 6,
    parameter int ADDR_BIT   = 6,
    parameter logic [WORD_BIT-1:0] MAGIC = 'h2A
) (
    input  logic                clk,
    input  logic                arstb,
    input  logic                start,
    input  logic                s_valid,
    input  logic [WORD_BIT-1:0] s_data,
    output logic                s_ready,
    output logic                wr_en,
    output logic [1:0]          wr_sel,
    output logic [ADDR_BIT-1:0] wr_addr,
    output logic [WORD_BIT-1:0] wr_data,
    output logic                cal_inhibit,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                params_valid
);

    localparam int W1_LEN = INPUT_NUM * NEURON_NUM;
    localparam int B1_LEN = NEURON_NUM;
    localparam int W2_LEN = NEURON_NUM * OUTPUT_NUM;
    localparam int B2_LEN = OUTPUT_NUM;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_W1, S_B1, S_W2, S_B2, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_BIT-1:0] idx;
    logic [ADDR_BIT-1:0] idx_last;
    logic [WORD_BIT-1:0] csum;
    logic [1:0]          bank_sel;
    logic                in_bank;
    logic                idle_like;
    logic                xfer;
    logic                bank_end;

    assign in_bank   = (state == S_W1) || (state == S_B1) || (state == S_W2) || (state == S_B2);
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign busy        = !idle_like;
    assign cal_inhibit = !idle_like;
    assign s_ready     = !idle_like;
    assign xfer        = s_valid && s_ready;
    assign bank_end    = (idx == idx_last);

    always_comb begin
        idx_last = '0;
        bank_sel = 2'd0;
        case (state)
            S_W1: begin idx_last = ADDR_BIT'(W1_LEN - 1); bank_sel = 2'd0; end
            S_B1: begin idx_last = ADDR_BIT'(B1_LEN - 1); bank_sel = 2'd1; end
            S_W2: begin idx_last = ADDR_BIT'(W2_LEN - 1); bank_sel = 2'd2; end
            S_B2: begin idx_last = ADDR_BIT'(B2_LEN - 1); bank_sel = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
            S_HDR: if (xfer) state_nxt = (s_data == MAGIC) ? S_W1 : S_ERR;
            S_W1:  if (xfer && bank_end) state_nxt = S_B1;
            S_B1:  if (xfer && bank_end) state_nxt = S_W2;
            S_W2:  if (xfer && bank_end) state_nxt = S_B2;
            S_B2:  if (xfer && bank_end) state_nxt = S_CHK;
            S_CHK: if (xfer) state_nxt = (s_data == csum) ? S_DONE : S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            idx          <= '0;
            csum         <= '0;
            wr_en        <= 1'b0;
            wr_sel       <= 2'd0;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            params_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (idle_like && start) begin
                idx          <= '0;
                csum         <= '0;
                done         <= 1'b0;
                err          <= 1'b0;
                params_valid <= 1'b0;
            end
            if (xfer && in_bank) begin
                wr_en   <= 1'b1;
                wr_sel  <= bank_sel;
                wr_addr <= idx;
                wr_data <= s_data;
                csum    <= csum ^ s_data;
                idx     <= bank_end ? '0 : idx + 1'b1;
            end
            if (xfer && (state == S_HDR) && (s_data != MAGIC))
                err <= 1'b1;
            if (xfer && (state == S_CHK)) begin
                if (s_data == csum) begin
                    done         <= 1'b1;
                    params_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Bench for mlp_param_loader: a word-count model of the framed stream checked
// every cycle, plus literal expectations on captured writes and final flags.
module tb_mlp_param_loader;

    localparam logic [5:0] MAGIC = 6'h2A;
    localparam int TOTAL = 84;

    logic       clk = 1'b0;
    logic       arstb = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [5:0] s_data = '0;
    logic       s_ready, wr_en, cal_inhibit, busy, done, err, params_valid;
    logic [1:0] wr_sel;
    logic [5:0] wr_addr, wr_data;

    mlp_param_loader dut (
        .clk(clk), .arstb(arstb), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .cal_inhibit(cal_inhibit), .busy(busy), .done(done),
        .err(err), .params_valid(params_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 done, 3 error; m_k = words after header (-1 = header next)
    int         m_phase, m_k;
    logic [5:0] m_csum;
    logic       m_wr, m_done, m_err, m_pv;
    logic [1:0] m_sel;
    logic [5:0] m_addr, m_data;

    always @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            m_phase = 0; m_k = -1; m_csum = '0;
            m_wr = 0; m_done = 0; m_err = 0; m_pv = 0;
            m_sel = '0; m_addr = '0; m_data = '0;
        end else begin
            m_wr = 0;
            if (m_phase != 1 && start) begin
                m_phase = 1; m_k = -1; m_csum = '0;
                m_done = 0; m_err = 0; m_pv = 0;
            end else if (m_phase == 1 && s_valid) begin
                if (m_k < 0) begin
                    if (s_data == MAGIC) m_k = 0;
                    else begin m_phase = 3; m_err = 1; end
                end else if (m_k < TOTAL) begin
                    if (m_k < 40)      begin m_sel = 2'd0; m_addr = 6'(m_k); end
                    else if (m_k < 48) begin m_sel = 2'd1; m_addr = 6'(m_k - 40); end
                    else if (m_k < 80) begin m_sel = 2'd2; m_addr = 6'(m_k - 48); end
                    else               begin m_sel = 2'd3; m_addr = 6'(m_k - 80); end
                    m_wr = 1; m_data = s_data;
                    m_csum = m_csum ^ s_data;
                    m_k++;
                end else begin
                    if (s_data == m_csum) begin m_phase = 2; m_done = 1; m_pv = 1; end
                    else begin m_phase = 3; m_err = 1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("wr_en", wr_en, m_wr);
        chk("wr_sel", wr_sel, m_sel);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("s_ready", s_ready, m_phase == 1);
        chk("busy", busy, m_phase == 1);
        chk("cal_inhibit", cal_inhibit, m_phase == 1);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("params_valid", params_valid, m_pv);
    end

    // Write capture for literal checks
    int          wcnt = 0;
    logic [13:0] wlog [0:1023];
    always @(negedge clk) begin
        if (wr_en) begin
            if (wcnt < 1024) wlog[wcnt] = {wr_sel, wr_addr, wr_data};
            wcnt++;
        end
    end

    task automatic send(input logic [5:0] w, input int gap);
        repeat (gap) begin s_valid = 1'b0; @(negedge clk); end
        s_valid = 1'b1; s_data = w;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic full_load(input logic [5:0] csum_word, input int gap, input bit rearm);
        pulse_start();
        send(MAGIC, 0);
        for (int k = 0; k < TOTAL; k++) begin
            if (rearm && k == 60) start = 1'b1;
            send(6'(k), (k == 0) ? 0 : gap);
            start = 1'b0;
        end
        send(csum_word, gap);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_count"}, wcnt - base, TOTAL);
        chk({tag, "_w1_first"}, wlog[base], {2'd0, 6'd0, 6'd0});
        chk({tag, "_w1_last"}, wlog[base + 39], {2'd0, 6'd39, 6'd39});
        chk({tag, "_b1_first"}, wlog[base + 40], {2'd1, 6'd0, 6'd40});
        chk({tag, "_b2_last"}, wlog[base + 83], {2'd3, 6'd3, 6'd19});
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err, params_valid}, 0);
        arstb = 1'b1;
        @(negedge clk);

        // Full load
        base = wcnt;
        full_load(6'h00, 0, 0);
        check_writes("full", base);
        chk("full_flags", {done, params_valid, err, busy}, 4'b1100);

        // Bad header, extra words offered afterwards must not be taken
        base = wcnt;
        pulse_start();
        send(6'h15, 0);
        send(6'h01, 0);
        send(6'h02, 0);
        #1;
        chk("badhdr_writes", wcnt - base, 0);
        chk("badhdr_flags", {err, done, params_valid, s_ready}, 4'b1000);
        @(negedge clk);

        // Bad checksum
        base = wcnt;
        full_load(6'h01, 0, 0);
        check_writes("badcsum", base);
        chk("badcsum_flags", {err, done, params_valid}, 3'b100);

        // Stalled stream
        base = wcnt;
        full_load(6'h00, 2, 0);
        check_writes("stall", base);
        chk("stall_flags", {done, params_valid, err}, 3'b110);

        // Reset mid-load after 30 W1 words
        pulse_start();
        send(MAGIC, 0);
        for (int k = 0; k < 30; k++) send(6'(k), 0);
        #2;
        arstb = 1'b0;
        #1;
        chk("midreset_outputs",
            {s_ready, wr_en, wr_sel, wr_addr, wr_data, cal_inhibit, busy, done, err, params_valid}, 0);
        @(negedge clk);
        arstb = 1'b1;
        @(negedge clk);
        base = wcnt;
        full_load(6'h00, 0, 0);
        check_writes("afterreset", base);
        chk("afterreset_flags", {done, params_valid, err}, 3'b110);

        // Start during W2 ignored, then re-arm from DONE
        base = wcnt;
        full_load(6'h00, 0, 1);
        check_writes("rearm", base);
        chk("rearm_flags", {done, params_valid, err}, 3'b110);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rearm_cleared", {done, params_valid, busy, s_ready}, 4'b0011);
        send(6'h00, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rearm_end_err", {err, busy}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mlp_param_loader.md
Name: mlp_param_loader

Overview:
Writer side of the MLP parameter-write interface. It accepts a framed word stream over a valid/ready handshake from the calibration host, and checks a header and an XOR checksum. It sequences the words into write strobes for the MLP core's four parameter banks: W1, B1, W2, B2. It also holds the core's calculation path off while loading, and flags whether the loaded parameter set is valid.

Parameters:
INPUT_NUM, 5, number of MLP inputs
NEURON_NUM, 8, number of hidden neurons
OUTPUT_NUM, 4, number of outputs
WORD_BIT, 6, parameter word width; equals the core's WEIGHT_BIT and BIAS_BIT
ADDR_BIT, 6, bank-local address width; 2^ADDR_BIT must be >= max(INPUT_NUM*NEURON_NUM, NEURON_NUM*OUTPUT_NUM)
MAGIC, 6'h2A, required header word

Ports:
clk  in  1  clock
arstb  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that arms a load
s_valid  in  1  stream word valid
s_data  in  WORD_BIT  stream word
s_ready  out  1  loader accepts a word
wr_en  out  1  one-cycle parameter write strobe to the MLP core
wr_sel  out  2  target bank: 0=W1, 1=B1, 2=W2, 3=B2
wr_addr  out  ADDR_BIT  bank-local index
wr_data  out  WORD_BIT  parameter value
cal_inhibit  out  1  high while busy; the core must not calculate
busy  out  1  load in progress
done  out  1  sticky; last load passed all checks
err  out  1  sticky; last load failed
params_valid  out  1  high only after a successful load, cleared at start

Behaviour:
- Reset: arstb low asynchronously clears all state and outputs to 0, and the FSM goes to IDLE.
  - Affected: s_ready, wr_en, wr_sel, wr_addr, wr_data, cal_inhibit, busy, done, err, params_valid, counters, checksum.
- Handshake: a word transfers on any rising edge with s_valid && s_ready.
  - s_ready is a registered-state decode: 1 in HDR, W1, B1, W2, B2 and CHK; 0 otherwise.
  - s_valid gaps are legal and stall the FSM with no side effects.
- FSM states: IDLE, HDR, W1, B1, W2, B2, CHK, DONE, ERR.
  - IDLE/DONE/ERR, start=1 -> HDR. This clears done, err, params_valid, the checksum and the index counter.
  - start while busy (HDR..CHK) is ignored.
  - HDR, transfer: s_data==MAGIC -> W1, otherwise -> ERR. The header is excluded from the checksum.
  - W1: INPUT_NUM*NEURON_NUM transfers, then B1.
  - B1: NEURON_NUM transfers, then W2.
  - W2: NEURON_NUM*OUTPUT_NUM transfers, then B2.
  - B2: OUTPUT_NUM transfers, then CHK.
  - The index counter resets to 0 at every bank change.
  - CHK, transfer: s_data == running XOR -> DONE (done=1, params_valid=1); otherwise -> ERR (err=1).
- Write generation: each transfer in W1..B2 produces wr_en=1 on the next cycle only.
  - That cycle carries wr_sel = current bank, wr_addr = index, wr_data = s_data.
  - Write latency is 1 cycle; back-to-back transfers give back-to-back strobes.
  - wr_sel, wr_addr and wr_data hold their last values when wr_en=0.
- Address order is row-major by source.
  - W1: addr = i*NEURON_NUM + j (input i, neuron j).
  - W2: addr = n*OUTPUT_NUM + o.
  - B1 and B2: addr = neuron or output index.
- Checksum: a WORD_BIT-wide XOR over all parameter words in W1..B2, updated on each transfer.
- busy = cal_inhibit = 1 in HDR..CHK.
- On ERR, already-written parameters remain in the core. params_valid=0 marks them unusable.
- Reset mid-load aborts with no further writes. The loader returns to IDLE with params_valid=0.
- Bank word counts are fixed by parameters. Extra words after CHK are not accepted (s_ready=0 in DONE/ERR).

Test Plan:
- Full load: start, then 0x2A, then 84 words k mod 64 (k=0..83), then checksum 0x00.
  - 84 wr_en pulses.
  - First W1 write: addr 0, data 0. Last W1 write: addr 39, data 39. First B1 write: sel 1, addr 0, data 40. Last B2 write: sel 3, addr 3, data 19.
  - done=1, params_valid=1, err=0, busy=0.
- Bad header: start, then 0x15 -> ERR, err=1, zero wr_en pulses, s_ready=0 afterwards.
- Bad checksum: same stream as Full load with final word 0x01.
  - 84 writes occur; err=1, done=0, params_valid=0.
- Stalls: Full load with s_valid toggling 1,0,0,1,...
  - Identical write sequence, each write one cycle after its transfer, same final result.
- Reset mid-load: assert arstb low after 30 W1 words.
  - All outputs 0 immediately.
  - A new start plus full stream completes normally, and W1 restarts at addr 0.
- Re-arm: start pulse during W2 is ignored and the load completes. A start from DONE clears done and params_valid on the next cycle, and the state goes to HDR.
